// File: rtl/muldiv_hilo_unit_pkg.sv
// rtl/muldiv_hilo_unit_pkg.sv - op encodings, FSM states and width default for the HI/LO mul/div unit
package muldiv_pkg;

  localparam int W_DEFAULT = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } state_t;

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// rtl/muldiv_hilo_unit_if.sv - request/result bundle between execute stage and the HI/LO mul/div unit
interface muldiv_hilo_unit_if
  import muldiv_pkg::*;
#(
  parameter int W = W_DEFAULT
);
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         flush;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (
    output start, op, opa, opb, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, opa, opb, flush,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - one shift-add multiply or restoring shift-subtract divide step on {acc, q}
module muldiv_iter_core #(
  parameter int W = 32
) (
  input  logic         is_div,
  input  logic [W-1:0] acc,
  input  logic [W-1:0] q,
  input  logic [W-1:0] m,
  output logic [W-1:0] acc_next,
  output logic [W-1:0] q_next
);

  logic [W:0] sum;
  logic [W:0] shifted;
  logic [W:0] diff;

  always_comb begin
    sum      = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    shifted  = {acc, q[W-1]};
    diff     = shifted - {1'b0, m};
    acc_next = sum[W:1];
    q_next   = {sum[0], q[W-1:1]};
    if (is_div) begin
      // bit W of diff is the borrow: set means the divisor did not fit
      if (!diff[W]) begin
        acc_next = diff[W-1:0];
        q_next   = {q[W-2:0], 1'b1};
      end else begin
        acc_next = shifted[W-1:0];
        q_next   = {q[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// rtl/muldiv_hilo_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI and LO registers
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  muldiv_hilo_unit_if.slave  bus
);

  localparam int CW = $clog2(W + 1);

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   acc, q, m, opa_hold, hi, lo;
  logic           is_div, neg_res, neg_rem, dbz_op, dbz, done;

  logic           idle_req, accept_md, fix_write;
  logic           sgn_op, a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag, acc_step, q_step, fix_hi, fix_lo;
  logic [2*W-1:0] prod;

  muldiv_iter_core #(.W(W)) u_core (
    .is_div   (is_div),
    .acc      (acc),
    .q        (q),
    .m        (m),
    .acc_next (acc_step),
    .q_next   (q_step)
  );

  // a flush in IDLE also swallows a same-cycle start
  always_comb begin
    idle_req  = (state == ST_IDLE) && bus.start && !bus.flush;
    accept_md = idle_req && !bus.op[2];
    sgn_op    = !bus.op[0];
    a_neg     = sgn_op && bus.opa[W-1];
    b_neg     = sgn_op && bus.opb[W-1];
    a_mag     = a_neg ? -bus.opa : bus.opa;
    b_mag     = b_neg ? -bus.opb : bus.opb;
  end

  always_comb begin
    state_next = state;
    fix_write  = 1'b0;
    unique case (state)
      ST_IDLE: if (accept_md) state_next = ST_RUN;
      ST_RUN: begin
        if (bus.flush)                 state_next = ST_IDLE;
        else if (cnt == CW'(W - 1))    state_next = ST_FIX;
      end
      ST_FIX: begin
        state_next = ST_IDLE;
        fix_write  = !bus.flush;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // remainder follows the dividend's sign; divide-by-zero returns the raw dividend
  always_comb begin
    prod = {acc, q};
    if (neg_res) prod = -prod;
    fix_hi = prod[2*W-1:W];
    fix_lo = prod[W-1:0];
    if (is_div) begin
      if (dbz_op) begin
        fix_hi = opa_hold;
        fix_lo = '1;
      end else begin
        fix_lo = neg_res ? -q : q;
        fix_hi = neg_rem ? -acc : acc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      opa_hold <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dbz_op   <= 1'b0;
      dbz      <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= fix_write;
      if (accept_md) begin
        cnt      <= '0;
        acc      <= '0;
        q        <= bus.op[1] ? a_mag : b_mag;
        m        <= bus.op[1] ? b_mag : a_mag;
        is_div   <= bus.op[1];
        neg_res  <= a_neg ^ b_neg;
        neg_rem  <= a_neg;
        dbz_op   <= bus.op[1] && (bus.opb == '0);
        opa_hold <= bus.opa;
        dbz      <= 1'b0;
      end else if (state == ST_RUN) begin
        cnt <= cnt + 1'b1;
        acc <= acc_step;
        q   <= q_step;
      end
      if (idle_req && bus.op == OP_MTHI) hi <= bus.opa;
      if (idle_req && bus.op == OP_MTLO) lo <= bus.opa;
      if (fix_write) begin
        hi  <= fix_hi;
        lo  <= fix_lo;
        dbz <= dbz_op;
      end
    end
  end

  assign bus.busy        = (state != ST_IDLE);
  assign bus.done        = done;
  assign bus.div_by_zero = dbz;
  assign bus.hi          = hi;
  assign bus.lo          = lo;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb/tb_muldiv_hilo_unit.sv - directed and random checks of muldiv_hilo_unit against an arithmetic model
module tb_muldiv_hilo_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  muldiv_hilo_unit_if #(.W(32)) u ();

  muldiv_hilo_unit #(.W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic z);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    z  = 1'b0;
    h  = '0;
    l  = '0;
    case (o)
      OP_MULT:  begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      OP_MULTU: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
      default: begin
        if (b == 0) begin
          z = 1'b1; h = a; l = 32'hFFFF_FFFF;
        end else if (o == OP_DIV) begin
          sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0];
        end else begin
          p = ua / ub; l = p[31:0]; p = ua % ub; h = p[31:0];
        end
      end
    endcase
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] eh, el;
    logic        ez;
    int          bc;
    logic        early;
    model(o, a, b, eh, el, ez);
    @(negedge clk);
    u.start = 1'b1; u.op = o; u.opa = a; u.opb = b;
    @(negedge clk);
    u.start = 1'b0;
    chk(u.div_by_zero, 0, {tag, ":dbz_clr"});
    bc = 0;
    early = 1'b0;
    while (u.busy === 1'b1 && bc < 100) begin
      if (u.done !== 1'b0) early = 1'b1;
      bc++;
      @(negedge clk);
    end
    chk(bc, 33, {tag, ":busy_cycles"});
    chk(early, 0, {tag, ":done_early"});
    chk(u.done, 1, {tag, ":done"});
    chk(u.hi, eh, {tag, ":hi"});
    chk(u.lo, el, {tag, ":lo"});
    chk(u.div_by_zero, ez, {tag, ":dbz"});
    @(negedge clk);
    chk(u.done, 0, {tag, ":done_pulse"});
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          bc;
    logic        saw;
    checks   = 0;
    failures = 0;
    clk = 1'b0;
    rst = 1'b1;
    u.start = 1'b0; u.op = 3'b111; u.opa = '0; u.opb = '0; u.flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk(u.busy, 0, "rst_busy");
    chk(u.done, 0, "rst_done");
    chk(u.div_by_zero, 0, "rst_dbz");
    chk(u.hi, 0, "rst_hi");
    chk(u.lo, 0, "rst_lo");

    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    chk({u.hi, u.lo}, 64'hFFFF_FFFF_FFFF_FFFA, "mult_neg_const");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    chk({u.hi, u.lo}, 64'hFFFF_FFFE_0000_0001, "multu_max_const");
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
    chk({u.hi, u.lo}, 64'hFFFF_FFFF_FFFF_FFFD, "div_neg_const");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_wrap");
    chk({u.hi, u.lo}, 64'h0000_0000_8000_0000, "div_wrap_const");
    run_op(OP_DIVU, 32'd7, 32'd0, "divu_zero");
    chk({u.hi, u.lo, 31'd0, u.div_by_zero}, {64'h0000_0007_FFFF_FFFF, 32'd1}, "divu_zero_const");
    run_op(OP_MULTU, 32'd1, 32'd1, "multu_one");
    run_op(OP_DIV, 32'h8000_0000, 32'd0, "div_zero_signed");

    for (int i = 0; i < 12; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) rb = '0;
      run_op(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro));
    end

    // requests while busy are dropped, not queued
    @(negedge clk);
    u.start = 1'b1; u.op = OP_MULTU; u.opa = 32'd3; u.opb = 32'd5;
    @(negedge clk);
    u.start = 1'b0;
    @(negedge clk);
    u.start = 1'b1; u.op = OP_MULTU; u.opa = 32'd2; u.opb = 32'd2;
    @(negedge clk);
    u.op = OP_MTHI; u.opa = 32'h1234;
    @(negedge clk);
    u.start = 1'b0;
    bc = 0;
    while (u.busy === 1'b1 && bc < 100) begin bc++; @(negedge clk); end
    chk(bc, 30, "ignore_busy_len");
    chk(u.done, 1, "ignore_done");
    chk(u.hi, 0, "ignore_hi");
    chk(u.lo, 15, "ignore_lo");
    @(negedge clk);
    chk(u.busy, 0, "ignore_no_requeue");

    u.start = 1'b1; u.op = OP_MTLO; u.opa = 32'hABCD;
    @(negedge clk);
    u.start = 1'b0;
    chk(u.lo, 32'hABCD, "mtlo_lo");
    chk(u.hi, 0, "mtlo_hi");
    chk(u.done, 0, "mtlo_done");
    chk(u.busy, 0, "mtlo_busy");
    u.start = 1'b1; u.op = OP_MTHI; u.opa = 32'h77;
    @(negedge clk);
    u.start = 1'b0;
    chk(u.hi, 32'h77, "mthi_hi");

    u.start = 1'b1; u.op = OP_DIVU; u.opa = 32'd1000; u.opb = 32'd7;
    @(negedge clk);
    u.start = 1'b0;
    repeat (10) @(negedge clk);
    u.flush = 1'b1;
    @(negedge clk);
    u.flush = 1'b0;
    chk(u.busy, 0, "flush_busy");
    chk({u.hi, u.lo}, {32'h77, 32'hABCD}, "flush_hilo");
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (u.done !== 1'b0 || u.busy !== 1'b0) saw = 1'b1;
      @(negedge clk);
    end
    chk(saw, 0, "flush_no_done");
    chk({u.hi, u.lo}, {32'h77, 32'hABCD}, "flush_hilo_late");

    u.start = 1'b1; u.op = OP_MULTU; u.opa = 32'd3; u.opb = 32'd3;
    @(negedge clk);
    u.start = 1'b0;
    repeat (32) @(negedge clk);
    chk(u.busy, 1, "flush_fix_in_fix");
    u.flush = 1'b1;
    @(negedge clk);
    u.flush = 1'b0;
    chk({u.hi, u.lo, 30'd0, u.busy, u.done}, {32'h77, 32'hABCD, 32'd0}, "flush_fix");

    u.start = 1'b1; u.flush = 1'b1; u.op = OP_MTHI; u.opa = 32'h5555;
    @(negedge clk);
    u.op = OP_MULT; u.opa = 32'd2; u.opb = 32'd2;
    @(negedge clk);
    u.start = 1'b0; u.flush = 1'b0;
    chk(u.hi, 32'h77, "flush_idle_mthi");
    chk(u.busy, 0, "flush_idle_mult");

    u.start = 1'b1; u.op = OP_DIV; u.opa = 32'd100; u.opb = 32'd3;
    @(negedge clk);
    u.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk({u.hi, u.lo, 31'd0, u.busy}, 96'd0, "rst_async");
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk({30'd0, u.busy, u.done}, 0, "rst_discard");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
Iterative multiply/divide unit that owns the HI and LO architectural registers of the execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from decode/execute. Its Hi and Lo outputs feed inputs 2 and 3 of the 32-bit 4:1 writeback-select mux, which MFHI/MFLO steer. Busy goes to the hazard unit, which stalls dependent instructions.

Parameters:
W, 32, operand/HI/LO width; the iteration count equals W.

Ports:
Clk  input  1  clock, all state on rising edge
Rst  input  1  asynchronous, active-high reset
Start  input  1  request valid for this cycle
Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
OpA  input  W  rs value (dividend / multiplicand / MTHI-MTLO source)
OpB  input  W  rt value (divisor / multiplier)
Flush  input  1  synchronous abort of an in-flight mul/div
Busy  output  1  mul/div in flight
Done  output  1  one-cycle pulse: Hi/Lo hold a new mul/div result
DivByZero  output  1  last divide had OpB==0
Hi  output  W  HI register
Lo  output  W  LO register

Behaviour:
- Reset (async, Rst=1): state IDLE; Hi, Lo, Busy, Done and DivByZero all 0; counter 0. Reset mid-operation discards the operation.
- States: IDLE, RUN, FIX.
- IDLE, Start=1, Op in {MULT, MULTU, DIV, DIVU}:
  - latch operand magnitudes; for signed ops use two's-complement abs, so 0x80000000 gives magnitude 0x80000000.
  - latch sign flags; go to RUN; Busy=1 from the next cycle; DivByZero cleared.
- IDLE, Start=1, Op=MTHI/MTLO: Hi/Lo <= OpA at that edge; stay IDLE; no Busy, no Done.
- Op 11x: no effect.
- RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle for exactly W cycles, then go to FIX.
- FIX (1 cycle): apply sign correction, write Hi/Lo at the exiting edge, go to IDLE.
  - Busy spans W+1 cycles.
  - Done=1 in the single cycle after that edge, coinciding with Busy=0 and the new Hi/Lo.
  - Latency: Start edge k -> Hi/Lo valid after edge k+W+1.
- Multiply result: {Hi,Lo} = full 2W-bit product. MULT negates the 2W-bit product if the operand signs differ.
- Divide result: Lo = quotient, Hi = remainder.
  - Signed: quotient negated if signs differ; remainder takes the dividend's sign (truncating division).
  - 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0 (wraps, no trap).
- Divide by zero (OpB==0, signed or unsigned):
  - Lo=all ones, Hi=OpA as presented.
  - DivByZero=1, held until the next mul/div is accepted.
  - Still takes the full W+1 cycles.
- Start while Busy (any Op, including MTHI/MTLO): ignored, nothing queued. The hazard unit must stall instead.
- Flush=1 in RUN or FIX: go to IDLE next edge, Hi/Lo unchanged, no Done.
  - Flush wins over the FIX-edge write.
  - Flush in IDLE: no effect, and a Start in the same cycle is ignored.
- Counter: ceil(log2(W+1)) bits; wraps are never observable.

Decomposition:
- Package muldiv_pkg holds:
  - the Op encodings (OP_MULT..OP_MTLO);
  - the state enum (ST_IDLE, ST_RUN, ST_FIX);
  - a W default constant.
- One sub-module, muldiv_iter_core: the combinational per-cycle step. Given {acc, q}, divisor/multiplicand and mode, it returns the next {acc, q}. The top level keeps the FSM, counter, sign fix-up and HI/LO.

Test Plan:
1. MULT OpA=0xFFFFFFFE, OpB=3 -> Busy 33 cycles; Done 1 cycle; Hi=0xFFFFFFFF, Lo=0xFFFFFFFA.
2. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
3. DIV -7 (0xFFFFFFF9) / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
4. DIVU 7 / 0 -> Lo=0xFFFFFFFF, Hi=7, DivByZero=1. Next MULTU 1x1 -> DivByZero=0 at accept, Lo=1.
5. While Busy, issue MULTU 2x2 and MTHI 0x1234 -> both ignored; the original result lands. Then MTLO 0xABCD in IDLE -> Lo=0xABCD after 1 edge, Done stays 0.
6. Flush at RUN cycle 10 -> Busy=0 next cycle, Hi/Lo unchanged, no Done. Rst pulse mid-DIV -> Hi=Lo=0, Busy=0 immediately (async).
